// File: rtl/leaf_pkg.sv
// Shared leaf packet definitions: field widths, bit offsets, sender FSM states and
// pack/unpack helpers used by both the sender and the leaf interface side.
package leaf_pkg;

  localparam int unsigned PayloadBits = 32;
  localparam int unsigned NumAddrBits = 7;
  localparam int unsigned NumPortBits = 4;
  localparam int unsigned NumLeafBits = 5;
  localparam int unsigned PacketBits  = 1 + NumLeafBits + NumPortBits + NumAddrBits + PayloadBits;

  localparam int unsigned PayloadLsb = 0;
  localparam int unsigned AddrLsb    = PayloadLsb + PayloadBits;
  localparam int unsigned PortLsb    = AddrLsb + NumAddrBits;
  localparam int unsigned LeafLsb    = PortLsb + NumPortBits;
  localparam int unsigned ValidBit   = LeafLsb + NumLeafBits;

  typedef struct packed {
    logic                   valid;
    logic [NumLeafBits-1:0] leaf;
    logic [NumPortBits-1:0] port;
    logic [NumAddrBits-1:0] addr;
    logic [PayloadBits-1:0] payload;
  } leaf_pkt_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitCredit,
    StDone
  } sender_state_e;

  function automatic logic [PacketBits-1:0] pack_pkt(input leaf_pkt_t p);
    logic [PacketBits-1:0] w;
    w                                = '0;
    w[ValidBit]                      = p.valid;
    w[LeafLsb +: NumLeafBits]        = p.leaf;
    w[PortLsb +: NumPortBits]        = p.port;
    w[AddrLsb +: NumAddrBits]        = p.addr;
    w[PayloadLsb +: PayloadBits]     = p.payload;
    return w;
  endfunction

  function automatic leaf_pkt_t unpack_pkt(input logic [PacketBits-1:0] w);
    leaf_pkt_t p;
    p.valid   = w[ValidBit];
    p.leaf    = w[LeafLsb +: NumLeafBits];
    p.port    = w[PortLsb +: NumPortBits];
    p.addr    = w[AddrLsb +: NumAddrBits];
    p.payload = w[PayloadLsb +: PayloadBits];
    return p;
  endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Saturating credit counter for the destination buffer: decodes credit-return packets,
// charges one slot per accepted word and flags (sticky) any update beyond capacity.
module leaf_credit_counter
  import leaf_pkg::*;
#(
  parameter int unsigned AddrBits   = NumAddrBits,
  parameter int unsigned UpdateSize = 64,
  parameter int unsigned SelfLeaf   = 1,
  parameter int unsigned CreditPort = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [PacketBits-1:0] pkt_i,
  input  logic                  restart_i,
  input  logic                  accept_i,
  output logic [AddrBits:0]     credit_o,
  output logic [AddrBits:0]     credit_next_o,
  output logic                  credit_err_o
);

  localparam int unsigned      SumBits  = AddrBits + 2;
  localparam logic [SumBits-1:0] CapWide  = SumBits'(2 ** AddrBits);
  localparam logic [SumBits-1:0] Update   = SumBits'(UpdateSize);
  localparam logic [AddrBits:0]  Full     = (AddrBits + 1)'(2 ** AddrBits);

  leaf_pkt_t          pkt;
  logic               credit_in;
  logic               overflow;
  logic [SumBits-1:0] sum;
  logic [AddrBits:0]  credit_q, credit_d;
  logic               err_q, err_d;
  logic               unused_pkt_fields;

  assign pkt       = unpack_pkt(pkt_i);
  assign credit_in = pkt.valid && (pkt.leaf == NumLeafBits'(SelfLeaf)) &&
                     (pkt.port == NumPortBits'(CreditPort));
  assign unused_pkt_fields = ^{pkt.addr, pkt.payload};

  // Accept only happens with credit != 0, so the subtraction cannot wrap.
  always_comb begin
    sum      = {1'b0, credit_q} - SumBits'(accept_i) + (credit_in ? Update : '0);
    overflow = sum > CapWide;
    credit_d = credit_q;
    err_d    = err_q;
    if (restart_i) begin
      credit_d = Full;
    end else if (overflow) begin
      credit_d = Full;
      err_d    = 1'b1;
    end else begin
      credit_d = sum[AddrBits:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_q <= Full;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_o      = credit_q;
  assign credit_next_o = credit_d;
  assign credit_err_o  = err_q;

endmodule

// File: rtl/leaf_stream_sender.sv
// Leaf packet transmitter: turns a vld/ack user stream into addressed BFT packets,
// throttled by credits returned from the destination leaf.
module leaf_stream_sender
  import leaf_pkg::*;
#(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
  parameter int unsigned DEST_LEAF             = 2,
  parameter int unsigned DEST_PORT             = 1,
  parameter int unsigned SELF_LEAF             = 1,
  parameter int unsigned CREDIT_PORT           = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [31:0]             len,
  input  logic [PAYLOAD_BITS-1:0] din_user,
  input  logic                    vld_user,
  output logic                    ack_user,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2sender,
  output logic [PACKET_BITS-1:0]  dout_sender2bft,
  input  logic                    resend,
  output logic                    done,
  output logic                    credit_err
);

  sender_state_e            state_q, state_d;
  logic [NUM_ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [31:0]              rem_q, rem_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     done_q;
  logic                     restart;
  logic                     accept;
  logic [NUM_ADDR_BITS:0]   credit;
  logic [NUM_ADDR_BITS:0]   credit_next;
  leaf_pkt_t                out_pkt;

  leaf_credit_counter #(
    .AddrBits   (NUM_ADDR_BITS),
    .UpdateSize (FREESPACE_UPDATE_SIZE),
    .SelfLeaf   (SELF_LEAF),
    .CreditPort (CREDIT_PORT)
  ) u_credit (
    .clk_i         (clk),
    .reset_i       (reset),
    .pkt_i         (din_leaf_bft2sender),
    .restart_i     (restart),
    .accept_i      (accept),
    .credit_o      (credit),
    .credit_next_o (credit_next),
    .credit_err_o  (credit_err)
  );

  assign ack_user = vld_user && (state_q == StSend) && (credit != '0) && !resend;
  assign accept   = ack_user;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rem_d   = rem_q;
    restart = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (ap_start) begin
          restart = 1'b1;
          wptr_d  = '0;
          rem_d   = len;
          state_d = (len == '0) ? StDone : StSend;
        end
      end
      StSend: begin
        if (accept) begin
          rem_d  = rem_q - 32'd1;
          wptr_d = wptr_q + NUM_ADDR_BITS'(1);
          if (rem_d == '0) begin
            state_d = StDone;
          end else if (credit_next == '0) begin
            state_d = StWaitCredit;
          end
        end
      end
      StWaitCredit: begin
        if (credit_next != '0) begin
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_pkt.valid   = 1'b1;
    out_pkt.leaf    = NUM_LEAF_BITS'(DEST_LEAF);
    out_pkt.port    = NUM_PORT_BITS'(DEST_PORT);
    out_pkt.addr    = wptr_q;
    out_pkt.payload = din_user;
    dout_d          = accept ? pack_pkt(out_pkt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      done_q  <= (state_d == StDone);
    end
  end

  assign dout_sender2bft = dout_q;
  assign done            = done_q;

endmodule

// File: tb/tb_leaf_stream_sender.sv
// Self-checking bench for leaf_stream_sender: table-driven transfers plus hand-written
// credit, overflow, filtering and reset sequences, with a packet scoreboard.
module tb_leaf_stream_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        ap_start;
  logic [31:0] len;
  logic [31:0] din_user;
  logic        vld_user;
  logic        ack_user;
  logic [48:0] din_leaf;
  logic [48:0] dout;
  logic        resend;
  logic        done;
  logic        credit_err;

  always #5 clk = ~clk;

  leaf_stream_sender dut (
    .clk                 (clk),
    .reset               (reset),
    .ap_start            (ap_start),
    .len                 (len),
    .din_user            (din_user),
    .vld_user            (vld_user),
    .ack_user            (ack_user),
    .din_leaf_bft2sender (din_leaf),
    .dout_sender2bft     (dout),
    .resend              (resend),
    .done                (done),
    .credit_err          (credit_err)
  );

  typedef struct {
    int unsigned len;
    logic [31:0] base;
    int unsigned rs_at;
    int unsigned rs_len;
  } vec_t;

  localparam logic [48:0] CreditPkt = {1'b1, 5'd1, 4'd0, 7'd0, 32'h0};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [48:0] exp_q[$];
  logic [6:0]  exp_addr;
  logic [31:0] word_base;
  int unsigned word_idx;
  int unsigned ack_cnt;
  logic        last_ack;
  logic        last_done;
  logic [48:0] last_dout;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive the stream word, sample just after the negedge, advance to next negedge.
  task automatic cycle();
    din_user = word_base + word_idx;
    #1;
    last_ack  = ack_user;
    last_done = done;
    last_dout = dout;
    if (dout[48]) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pkt: got %0h expected none", dout);
      end else begin
        check("pkt", 64'(dout), 64'(exp_q.pop_front()));
      end
    end else begin
      check("dout_zero", 64'(dout), 64'd0);
    end
    if (ack_user && !reset) begin
      exp_q.push_back({1'b1, 5'd2, 4'd1, exp_addr, din_user});
      exp_addr = exp_addr + 7'd1;
      word_idx++;
      ack_cnt++;
    end
    @(negedge clk);
    ap_start = 1'b0;
    din_leaf = '0;
  endtask

  task automatic start(input logic [31:0] n, input logic [31:0] base);
    ap_start  = 1'b1;
    len       = n;
    word_base = base;
    word_idx  = 0;
    exp_addr  = '0;
    ack_cnt   = 0;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    ack_cnt = 0;
  endtask

  task automatic run_acks(input int unsigned target, input int unsigned budget);
    int unsigned c = 0;
    while (ack_cnt < target && c < budget) begin
      cycle();
      c++;
    end
    check("ack_target", 64'(ack_cnt), 64'(target));
  endtask

  task automatic expect_stall(input int unsigned total);
    repeat (3) begin
      cycle();
      check("stall_noack", 64'(last_ack), 64'd0);
    end
    check("stall_count", 64'(ack_cnt), 64'(total));
  endtask

  task automatic run_to_done(input int unsigned budget);
    int unsigned c = 0;
    last_done = 1'b0;
    while (!last_done && c < budget) begin
      cycle();
      c++;
    end
    check("reach_done", 64'(last_done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned c = 0;
    logic seen = 1'b0;
    start(v.len, v.base);
    while (!seen && c < 200) begin
      resend = (v.rs_len != 0) && (c >= v.rs_at) && (c < v.rs_at + v.rs_len);
      cycle();
      if (resend) check("resend_noack", 64'(last_ack), 64'd0);
      c++;
      seen = last_done;
    end
    resend = 1'b0;
    check("vec_done_cycle", 64'(c), 64'(v.len + v.rs_len + 1));
    check("vec_acks", 64'(ack_cnt), 64'(v.len));
    check("vec_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ap_start = 1'b0; len = '0; vld_user = 1'b0; din_user = '0;
    din_leaf = '0; resend = 1'b0; word_base = '0; word_idx = 0; exp_addr = '0; ack_cnt = 0;
    vecs[0] = '{4,  32'hA0, 0,  0};
    vecs[1] = '{1,  32'hB0, 0,  0};
    vecs[2] = '{0,  32'hC0, 0,  0};
    vecs[3] = '{9,  32'hD0, 4,  3};
    vecs[4] = '{20, 32'hE0, 10, 1};
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    vld_user = 1'b1;

    cycle();
    check("rst_ack", 64'(last_ack), 64'd0);
    check("rst_dout", 64'(last_dout), 64'd0);
    check("rst_done", 64'(last_done), 64'd0);
    check("rst_err", 64'(credit_err), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Credit exhaustion, filtered packets while waiting, then two replenishments.
    do_reset();
    start(200, 32'h1000);
    run_acks(128, 300);
    expect_stall(128);
    din_leaf = {1'b1, 5'd1, 4'd3, 7'd0, 32'h0};
    cycle();
    din_leaf = {1'b1, 5'd4, 4'd0, 7'd0, 32'h0};
    cycle();
    din_leaf = {1'b0, 5'd1, 4'd0, 7'd0, 32'h0};
    cycle();
    expect_stall(128);
    din_leaf = CreditPkt;
    cycle();
    check("credit_cycle_noack", 64'(last_ack), 64'd0);
    cycle();
    check("credit_next_ack", 64'(last_ack), 64'd1);
    run_acks(192, 100);
    expect_stall(192);
    din_leaf = CreditPkt;
    cycle();
    run_to_done(40);
    check("exh_total", 64'(ack_cnt), 64'd200);
    check("exh_drained", 64'(exp_q.size()), 64'd0);

    // Credit arrives in the same cycle as the accept that empties the counter.
    do_reset();
    start(200, 32'h2000);
    run_acks(127, 300);
    din_leaf = CreditPkt;
    cycle();
    check("simul_128th", 64'(last_ack), 64'd1);
    cycle();
    check("simul_no_bubble", 64'(last_ack), 64'd1);
    run_acks(192, 100);
    expect_stall(192);

    // Filtering in IDLE, then overflow with sticky error and saturation.
    do_reset();
    din_leaf = {1'b1, 5'd1, 4'd3, 7'd0, 32'h0};
    cycle();
    din_leaf = {1'b1, 5'd3, 4'd0, 7'd0, 32'h0};
    cycle();
    cycle();
    check("filter_no_err", 64'(credit_err), 64'd0);
    din_leaf = CreditPkt;
    cycle();
    cycle();
    check("ovf_err", 64'(credit_err), 64'd1);
    start(200, 32'h3000);
    run_acks(128, 300);
    expect_stall(128);
    check("err_sticky", 64'(credit_err), 64'd1);
    do_reset();
    cycle();
    check("err_cleared", 64'(credit_err), 64'd0);

    // Reset after ten words: in-flight word dropped, credit back to full.
    start(50, 32'h4000);
    run_acks(10, 50);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    cycle();
    check("midrst_dout", 64'(last_dout), 64'd0);
    check("midrst_ack", 64'(last_ack), 64'd0);
    start(200, 32'h5000);
    run_acks(128, 300);
    expect_stall(128);

    // Zero-length start straight after reset.
    do_reset();
    start(0, 32'h6000);
    cycle();
    check("zero_done", 64'(last_done), 64'd1);
    check("zero_ack", 64'(last_ack), 64'd0);
    cycle();
    check("zero_nopkt", 64'(last_dout), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_stream_sender.md
# leaf_stream_sender

Transmitter end of the leaf packet protocol: accepts a 32-bit user stream on a vld/ack handshake and emits 49-bit BFT packets addressed to one destination leaf input port. Tracks the receiver's free buffer space with a credit counter replenished by freespace-update packets, so the destination BRAM never overruns. Sits on the BFT side of a leaf, for example in a test harness or DMA injector, and drives the same packet format a leaf shell's interface consumes.

## Interface
- PACKET_BITS, 49: packet width; must equal 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS.
- PAYLOAD_BITS, 32: payload width.
- NUM_LEAF_BITS, 5; NUM_PORT_BITS, 4; NUM_ADDR_BITS, 7: header field widths.
- FREESPACE_UPDATE_SIZE, 64: slots granted per credit packet.
- DEST_LEAF, 2; DEST_PORT, 1: destination leaf and input port.
- SELF_LEAF, 1; CREDIT_PORT, 0: header that identifies credit packets addressed to this sender.
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  one-cycle pulse; starts a transfer (IDLE only).
- len  in  32  words to send; sampled on ap_start.
- din_user  in  32  stream payload.
- vld_user  in  1  din_user valid.
- ack_user  out  1  word accepted this cycle.
- din_leaf_bft2sender  in  49  packets from the BFT (credit returns).
- dout_sender2bft  out  49  packets to the BFT; all-zero when idle.
- resend  in  1  stall: no word is accepted while high.
- done  out  1  high in DONE.
- credit_err  out  1  sticky: a credit update would exceed capacity.

## Operation
- Packet layout (MSB to LSB): [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- Credit packet: bit 48 = 1, leaf = SELF_LEAF, port = CREDIT_PORT. Payload is ignored. Any other packet is ignored.
- Credit counter: width NUM_ADDR_BITS+1. Reset and ap_start value is 2^NUM_ADDR_BITS (128).
- Credit update in one cycle: credit_next = credit − accept + (credit_in ? FREESPACE_UPDATE_SIZE : 0).
- If credit_next would exceed 128, the counter saturates at 128 and credit_err sets. credit_err clears only on reset.
- Write pointer wptr (NUM_ADDR_BITS): cleared on reset and on ap_start. Increments per accepted word and wraps 127 to 0. It fills the addr field.
- Remaining count rem (32 bits): loaded with len on ap_start; decrements per accepted word.
- ack_user = vld_user && state==SEND && credit!=0 && !resend. This is combinational from the registered state.
- State machine:
  - IDLE: ap_start with len==0 goes to DONE; ap_start with len!=0 goes to SEND.
  - SEND: goes to DONE on the accept that makes rem 0. Goes to WAIT_CREDIT when credit_next==0 and rem_next!=0.
  - WAIT_CREDIT: goes to SEND when credit_next!=0. Credit packets are processed in every state.
  - DONE: done=1; goes to IDLE on the next ap_start, which is also processed as a fresh start.
- ap_start outside IDLE/DONE is ignored.
- Reset values: all outputs 0 (ack_user=0, dout=0, done=0, credit_err=0). State IDLE, credit 128.
- Reset mid-transfer: the next cycle is IDLE with dout=0. Any in-flight packet is dropped.

## Timing
- A word accepted in cycle t appears on dout_sender2bft in cycle t+1 with bit 48=1, for exactly one cycle.
- Throughput: 1 word per cycle while credit>0.
- A credit packet seen in cycle t is usable for an accept in cycle t+1.
- Credit arriving in the same cycle as an accept that drops credit to 0 keeps the state SEND, with no bubble.
- resend high in cycle t: no accept in t. The packet from t−1 is still emitted in t.

## Structure
- Shared package leaf_pkg holds the field widths, the bit-offset constants for valid/leaf/port/addr/payload, and a pack/unpack function pair. The same offsets are used by the leaf interface side.
- Sub-module leaf_credit_counter holds the saturating credit counter, the credit decode and credit_err. The FSM, wptr, rem and the output register stay in leaf_stream_sender.

## Test plan
- Basic transfer: ap_start with len=4, vld_user held high, payloads 0xA0..0xA3.
  - Required: four packets on consecutive cycles starting one cycle after the first ack. Header leaf=2, port=1, addr 0..3.
  - done rises the cycle after the last accept.
- Credit exhaustion: len=200, no credit packets.
  - Required: exactly 128 packets with addr 0..127, then WAIT_CREDIT with ack_user=0.
  - One credit packet resumes sending: 64 more packets with addr 0..63, then a stall again.
- Simultaneous events: a credit packet arrives in the same cycle the 128th word is accepted.
  - Required: no stall cycle; the next word is accepted the following cycle.
- Overflow: inject a credit packet while credit=128.
  - Required: credit stays 128 and credit_err=1 until reset.
- resend and filtering:
  - resend high for 3 cycles mid-stream gives no acks during them and a contiguous addr sequence afterwards.
  - A packet with port=3 or leaf≠1 leaves credit unchanged.
- Reset mid-transfer and zero length:
  - Reset at word 10 makes dout=0 the next cycle and returns credit to 128.
  - A fresh ap_start with len=0 gives done the next cycle and no packets.
